// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with a frame-latched shadow word.
// Optional leading-zero suppression is enabled by defining SEVSEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] disp,
  input  logic        en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       nib;
  logic             digit_blank;
  logic             show;
  logic [3:0]       nib_sel [4];

  function automatic logic [6:0] hex_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_sel[gi] = shadow_q[4*gi +: 4];
    end
  endgenerate

  // Slot counter, digit index and frame-end shadow reload.
  always_comb begin
    slot_end     = (div_cnt_q == CNT_LAST);
    frame_end    = slot_end && (digit_q == 2'd3);
    div_cnt_d    = slot_end ? '0 : div_cnt_q + CNT_W'(1);
    digit_d      = slot_end ? digit_q + 2'd1 : digit_q;
    shadow_d     = frame_end ? disp : shadow_q;
    frame_tick_d = frame_end;
  end

  assign nib = nib_sel[digit_q];

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [3:0] nib_zero;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_zero
      assign nib_zero[gi] = (nib_sel[gi] == 4'h0);
    end
  endgenerate

  // A digit goes dark only if it and everything to its left are zero.
  always_comb begin
    digit_blank = 1'b0;
    case (digit_q)
      2'd3:    digit_blank = nib_zero[3];
      2'd2:    digit_blank = &nib_zero[3:2];
      2'd1:    digit_blank = &nib_zero[3:1];
      default: digit_blank = 1'b0;
    endcase
  end
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    show = en && (div_cnt_q >= CNT_BLANK) && !digit_blank;
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if (show) begin
      an_d  = ~(4'b0001 << digit_q);
      seg_d = hex_decode(nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      digit_q      <= 2'd0;
      shadow_q     <= 16'h0000;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: displayed words are queued when driven and
// popped at each observed frame boundary, then every output cycle is checked.
module tb_seven_seg_scan;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * RDIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] disp;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  int          checks;
  int          errors;
  int          pos;
  logic [15:0] cur_word;
  logic [15:0] word_q [$];

  seven_seg_scan #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp       (disp),
    .en         (en),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] exp_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return p;
  endfunction

  function automatic bit exp_suppressed(input logic [15:0] w, input int d);
    bit lz;
    lz = 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    lz = 1'b1;
`endif
    return lz && (d != 0) && ((w >> (4 * d)) == 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock; compare outputs against the expected frame at slot position pos.
  task automatic cycle();
    logic       en_edge;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         d;
    bit         act;
    en_edge = en;
    @(posedge clk);
    #1;
    d   = pos / RDIV;
    act = en_edge && ((pos % RDIV) >= BLANK) && !exp_suppressed(cur_word, d);
    exp_an  = 4'b1111;
    exp_seg = 7'h7F;
    if (act) begin
      exp_an[d] = 1'b0;
      exp_seg   = exp_decode(cur_word[4*d +: 4]);
    end
    check("an", {12'h000, an}, {12'h000, exp_an});
    check("seg", {9'h000, seg}, {9'h000, exp_seg});
    check("frame_tick", {15'h0000, frame_tick}, {15'h0000, (pos == FRAME - 1)});
    if (pos == FRAME - 1) begin
      pos = 0;
      while (word_q.size() > 0) cur_word = word_q.pop_front();
      $display("frame boundary at t=%0t, next frame shows %h", $time, cur_word);
    end else begin
      pos++;
    end
  endtask

  task automatic drive_word(input logic [15:0] w);
    disp = w;
    word_q.push_back(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, {12'h000, an}, 16'h000F);
    check({tag, "_seg"}, {9'h000, seg}, 16'h007F);
    check({tag, "_tick"}, {15'h0000, frame_tick}, 16'h0000);
  endtask

  task automatic release_reset();
    rst_n    = 1'b1;
    pos      = 0;
    cur_word = 16'h0000;
    word_q.delete();
    word_q.push_back(disp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    en     = 1'b1;
    disp   = 16'h1234;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_outputs("por_hold");
    end
    release_reset();

    $display("phase: scan order, first frame 0000 then 1234");
    repeat (3 * FRAME) cycle();

    $display("phase: shadow timing, 1234 -> ABCD mid-frame");
    while (pos != 12) cycle();
    drive_word(16'hABCD);
    repeat (FRAME - 12 + 2 * FRAME) cycle();

    $display("phase: enable drop during active slot");
    while ((pos % RDIV) != 4) cycle();
    en = 1'b0;
    cycle();
    check("en_off_an", {12'h000, an}, 16'h000F);
    check("en_off_seg", {9'h000, seg}, 16'h007F);
    repeat (FRAME + 8) cycle();
    en = 1'b1;
    repeat (10) cycle();

    $display("phase: full hex decode");
    drive_word(16'h3210);
    repeat (FRAME) cycle();
    drive_word(16'h7654);
    repeat (FRAME) cycle();
    drive_word(16'hBA98);
    repeat (FRAME) cycle();
    drive_word(16'hFEDC);
    repeat (2 * FRAME) cycle();

    $display("phase: leading-zero word 0042");
    drive_word(16'h0042);
    repeat (3 * FRAME) cycle();

    $display("phase: reset mid-slot with digit 0 active");
    while (pos != 5) cycle();
    check("pre_reset_an", {12'h000, an}, 16'h000E);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_hold");
    release_reset();
    cycle();
    cycle();
    check("post_rst_blank_an", {12'h000, an}, 16'h000F);
    cycle();
    check("post_rst_first_an", {12'h000, an}, 16'h000E);
    check("post_rst_first_seg", {9'h000, seg}, 16'h0040);
    repeat (2 * FRAME) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

- Time-multiplexed driver for the board's four common-anode seven-segment digits.
- Takes the 16-bit packed display word from the count decoder (four hex nibbles, nibble 0 rightmost) and scans one digit at a time.
- Decodes each nibble to segment patterns and drives anodes and segments.
- Sits between the display-word producer and the FPGA pins; all outputs are registered.

## Interface

- REFRESH_DIV, 100000: clock cycles each digit is selected; must be ≥ 4.
- BLANK_CYCLES, 16: cycles at the start of each digit slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- disp  input  16  packed display word; nibble k = disp[4k+3:4k] shows on digit k.
- en  input  1  display enable; 0 blanks all anodes.
- an  output  4  anode enables, active-low; an[k] selects digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_tick  output  1  one-cycle pulse in the cycle the shadow word is reloaded.

## Operation

- **Slot counter** `div_cnt` (width clog2(REFRESH_DIV)) counts 0..REFRESH_DIV-1, then wraps to 0.
- **Digit index** `digit` (2 bits) increments mod 4 when `div_cnt` wraps. The scan order is 0,1,2,3,0…
- **Frame end** is `digit`==3 and `div_cnt`==REFRESH_DIV-1.
  - At frame end, `shadow` <= `disp`.
  - `frame_tick` goes 1 for that one cycle only.
  - `disp` is sampled only at frame end, so there is no tearing within a frame.
- **Current nibble:** `nib` = `shadow[4·digit+3 : 4·digit]`.
- **Hex decode** (seg, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- **Anode selection:**
  - `an` = ~(1<<`digit`) when `en`=1, `div_cnt` ≥ BLANK_CYCLES, and the digit is not suppressed (see Configuration).
  - Otherwise `an` = 4'b1111.
  - `seg` = decode(`nib`) whenever `an` ≠ 1111; otherwise `seg` = 7'h7F.
- **`en` behaviour:** `en`=0 does not stop the counters or the shadow reload, only the outputs.
- **Reset values:**
  - `div_cnt`=0, `digit`=0, `shadow`=16'h0000.
  - `an`=4'b1111, `seg`=7'h7F, `frame_tick`=0.
- **Reset asserted mid-frame:** all state clears immediately (asynchronously). After release, scanning restarts at digit 0, slot cycle 0.

## Timing

- **Output latency:** `an`/`seg` are registered from the current `div_cnt`, `digit`, and `shadow`, so they change 1 cycle after those values change.
- **Digit slot:**
  - Per digit, `an` is 1111 for BLANK_CYCLES cycles, then active for REFRESH_DIV−BLANK_CYCLES cycles.
  - Frame period = 4·REFRESH_DIV cycles.
- **`disp` to pins:** a change on `disp` appears on the pins starting with digit 0 of the next frame, with worst-case latency 4·REFRESH_DIV+1 cycles.
- **First frame after reset:** shows 0000 (the shadow is cleared by reset).
- **`frame_tick`:**
  - Registered.
  - High in the cycle after the frame-end condition, which is the same cycle `shadow` holds the new value.
- **Coincident change at frame end:** if `disp` changes in the same cycle as the frame end, the value present at that clock edge is captured.
- **`en` changes:** take effect on `an`/`seg` one cycle later, regardless of slot position.

## Configuration

- **SEVSEG_LEADING_ZERO_BLANK_EN**
  - Defined: digit k (k = 3,2,1) is suppressed when its nibble and all nibbles above it are 0. Digit 0 is never suppressed. Example: 16'h0042 lights only digits 1 and 0.
  - Undefined: no suppression; all four digits are always shown, including leading zeros.

## Test plan

Benches use REFRESH_DIV=8, BLANK_CYCLES=2.

- **Reset:** assert rst_n=0 mid-slot with `an` active -> `an`=1111, `seg`=7F, `frame_tick`=0 immediately. After release, the first active `an`=1110 appears 3 cycles later, with `seg`=40.
- **Scan order:** disp=16'h1234, en=1, run 2 frames.
  - Second frame: `an` = 1110/1101/1011/0111 with `seg` = 19/30/24/79.
  - Each digit is active 6 cycles and blank 2 cycles.
  - `frame_tick` pulses every 32 cycles.
- **Shadow timing:** change disp from 16'h1234 to 16'hABCD mid-frame.
  - The remaining digits still show 1234 values.
  - The next frame shows `seg` = 21/46/03/08 for digits 0..3.
- **Enable:** drop en=0 during an active slot -> `an`=1111, `seg`=7F next cycle. `frame_tick` keeps pulsing every 32 cycles.
- **Full hex decode:** cycle disp through 16'h0000..16'hFFFF nibble patterns (e.g. 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC) -> every `seg` value matches the decode list.
- **Leading-zero blank:** disp=16'h0042.
  - With SEVSEG_LEADING_ZERO_BLANK_EN: digits 3 and 2 keep `an`=1111 for their whole slot; digit 1 shows 19, digit 0 shows 24.
  - Without the macro: digits 3 and 2 show 40.
